// File: rtl/sincos_cordic_if.sv
// sincos_cordic handshake bundle: start/angle request, busy/valid status,
// sin/cos results. master = requester, slave = CORDIC engine.
interface sincos_cordic_if #(
  parameter int D_WIDTH = 32
);
  logic                      start;
  logic [15:0]               angle;
  logic                      busy;
  logic                      valid;
  logic signed [D_WIDTH-1:0] sin;
  logic signed [D_WIDTH-1:0] cos;

  modport master (
    output start, angle,
    input  busy, valid, sin, cos
  );

  modport slave (
    input  start, angle,
    output busy, valid, sin, cos
  );
endinterface

// File: rtl/sincos_cordic.sv
// Iterative 14-step CORDIC sine/cosine, one result per 16 cycles.
// Ports: clk, rst_n (async low), io (slave: start/angle in, busy/valid/sin/cos out).
module sincos_cordic #(
  parameter int D_WIDTH = 32,
  parameter int Q_BITS  = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  sincos_cordic_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    OUT
  } state_t;

  localparam int SH = 16 - Q_BITS;
  localparam logic signed [19:0] K   = 20'sd39797;
  localparam logic signed [19:0] RND = 20'sd1 <<< (15 - Q_BITS);

  state_t             st;
  logic signed [19:0] x;
  logic signed [19:0] y;
  logic signed [15:0] z;
  logic [3:0]         cnt;
  logic               neg;

  logic signed [15:0] at;
  logic signed [19:0] xs;
  logic signed [19:0] ys;
  logic signed [19:0] xr;
  logic signed [19:0] yr;
  logic signed [19:0] xo;
  logic signed [19:0] yo;
  logic               flip;
  logic [15:0]        z0;
  logic               d;

  always_comb begin
    at = '0;
    case (cnt)
      4'd0:  at = 16'sd8192;
      4'd1:  at = 16'sd4836;
      4'd2:  at = 16'sd2555;
      4'd3:  at = 16'sd1297;
      4'd4:  at = 16'sd651;
      4'd5:  at = 16'sd326;
      4'd6:  at = 16'sd163;
      4'd7:  at = 16'sd81;
      4'd8:  at = 16'sd41;
      4'd9:  at = 16'sd20;
      4'd10: at = 16'sd10;
      4'd11: at = 16'sd5;
      4'd12: at = 16'sd3;
      4'd13: at = 16'sd1;
      default: at = '0;
    endcase
  end

  assign xs = x >>> cnt;
  assign ys = y >>> cnt;
  assign d  = ~z[15];

  // Quadrants 1 and 2 are rotated by pi into [-pi/2, pi/2);
  // adding 0x8000 is just flipping the MSB.
  assign flip = io.angle[15] ^ io.angle[14];
  assign z0   = flip ? {~io.angle[15], io.angle[14:0]} : io.angle;

  assign xr = (x + RND) >>> SH;
  assign yr = (y + RND) >>> SH;
  assign xo = neg ? -xr : xr;
  assign yo = neg ? -yr : yr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      io.busy  <= 1'b0;
      io.valid <= 1'b0;
      io.sin   <= '0;
      io.cos   <= '0;
    end else begin
      io.valid <= 1'b0;
      case (st)
        IDLE: begin
          if (io.start) begin
            x       <= K;
            y       <= '0;
            z       <= z0;
            neg     <= flip;
            cnt     <= '0;
            io.busy <= 1'b1;
            st      <= ROT;
          end
        end
        ROT: begin
          if (d) begin
            x <= x - ys;
            y <= y + xs;
            z <= z - at;
          end else begin
            x <= x + ys;
            y <= y - xs;
            z <= z + at;
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'd13) st <= OUT;
        end
        OUT: begin
          io.sin   <= D_WIDTH'(yo);
          io.cos   <= D_WIDTH'(xo);
          io.valid <= 1'b1;
          io.busy  <= 1'b0;
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_cordic.sv
// Directed testbench for sincos_cordic: table of angles with
// hand-computed sin/cos, plus restart, back-to-back and reset corners.
module tb_sincos_cordic;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  sincos_cordic_if #(.D_WIDTH(32)) io ();

  sincos_cordic #(.D_WIDTH(32), .Q_BITS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] angle;
    int          s;
    int          c;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int df;
    n_cmp++;
    df = act - exp;
    if (df < 0) df = -df;
    if (df > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic start_conv(input logic [15:0] a);
    @(negedge clk);
    io.start = 1'b1;
    io.angle = a;
    @(posedge clk);
    #1;
    io.start = 1'b0;
  endtask

  // Called just after the accepting edge; watches 25 further edges.
  task automatic watch(output int lat, output int nval, output int nbusy,
                       output int s, output int c);
    lat   = -1;
    nval  = 0;
    nbusy = io.busy ? 1 : 0;
    s     = 0;
    c     = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (io.busy) nbusy++;
      if (io.valid) begin
        nval++;
        if (lat < 0) begin
          lat = i;
          s   = int'(io.sin);
          c   = int'(io.cos);
        end
      end
    end
  endtask

  initial begin
    int lat, nv, nb, s, c;
    int zero_bad;
    logic [15:0] b2b [4];
    int vcnt;
    int bi;

    n_cmp = 0;
    n_bad = 0;
    io.start = 1'b0;
    io.angle = '0;

    tbl[0] = '{16'h0000,     0,  1024};
    tbl[1] = '{16'h4000,  1024,     0};
    tbl[2] = '{16'h8000,     0, -1024};
    tbl[3] = '{16'hC000, -1024,     0};
    tbl[4] = '{16'h2AAB,   887,   512};
    tbl[5] = '{16'h5555,   887,  -512};
    tbl[6] = '{16'hAAAB,  -887,  -512};
    tbl[7] = '{16'hD555,  -887,   512};

    rst_n = 1'b0;
    #23;
    chk("rst_busy", int'(io.busy), 0, 0);
    chk("rst_valid", int'(io.valid), 0, 0);
    chk("rst_sin", int'(io.sin), 0, 0);
    chk("rst_cos", int'(io.cos), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    zero_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (io.busy || io.valid || io.sin != 0 || io.cos != 0) zero_bad++;
    end
    chk("idle_outputs_zero", zero_bad, 0, 0);

    for (int i = 0; i < 8; i++) begin
      start_conv(tbl[i].angle);
      watch(lat, nv, nb, s, c);
      chk($sformatf("lat_%h", tbl[i].angle), lat, 15, 0);
      chk($sformatf("nvalid_%h", tbl[i].angle), nv, 1, 0);
      chk($sformatf("busy_%h", tbl[i].angle), nb, 15, 0);
      chk($sformatf("sin_%h", tbl[i].angle), s, tbl[i].s, 1);
      chk($sformatf("cos_%h", tbl[i].angle), c, tbl[i].c, 1);
      chk($sformatf("hold_sin_%h", tbl[i].angle), int'(io.sin), s, 0);
    end

    // Re-start while busy must be ignored.
    start_conv(16'h2AAB);
    nv  = 0;
    lat = -1;
    s   = 0;
    c   = 0;
    for (int i = 1; i <= 35; i++) begin
      if (i == 5) begin
        @(negedge clk);
        io.start = 1'b1;
        io.angle = 16'h8000;
      end
      @(posedge clk);
      #1;
      io.start = 1'b0;
      if (io.valid) begin
        nv++;
        if (lat < 0) begin
          lat = i;
          s   = int'(io.sin);
          c   = int'(io.cos);
        end
      end
    end
    chk("restart_nvalid", nv, 1, 0);
    chk("restart_lat", lat, 15, 0);
    chk("restart_sin", s, 887, 1);
    chk("restart_cos", c, 512, 1);

    // Back-to-back with start held high.
    b2b[0] = 16'h0000;
    b2b[1] = 16'h5555;
    b2b[2] = 16'hC000;
    b2b[3] = 16'h2AAB;
    @(negedge clk);
    io.start = 1'b1;
    io.angle = b2b[0];
    bi   = 1;
    vcnt = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc % 16 == 0 && bi < 4) begin
        io.angle = b2b[bi];
        bi++;
      end
      if (io.valid) begin
        chk($sformatf("b2b_time_%0d", vcnt), cyc, 15 + 16 * vcnt, 0);
        if (vcnt < 4) begin
          for (int k = 0; k < 8; k++) begin
            if (tbl[k].angle == b2b[vcnt]) begin
              chk($sformatf("b2b_sin_%0d", vcnt), int'(io.sin), tbl[k].s, 1);
              chk($sformatf("b2b_cos_%0d", vcnt), int'(io.cos), tbl[k].c, 1);
            end
          end
        end
        vcnt++;
      end
    end
    io.start = 1'b0;
    chk("b2b_count", vcnt, 4, 0);
    repeat (20) @(posedge clk);

    // Reset in the middle of the rotation.
    start_conv(16'h0000);
    repeat (7) @(posedge clk);
    #1;
    chk("midrun_busy_before", int'(io.busy), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("midrun_busy", int'(io.busy), 0, 0);
    chk("midrun_valid", int'(io.valid), 0, 0);
    chk("midrun_sin", int'(io.sin), 0, 0);
    chk("midrun_cos", int'(io.cos), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_conv(16'hD555);
    watch(lat, nv, nb, s, c);
    chk("post_rst_lat", lat, 15, 0);
    chk("post_rst_nvalid", nv, 1, 0);
    chk("post_rst_sin", s, -887, 1);
    chk("post_rst_cos", c, 512, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
